// File: rtl/rv32_decode_pipe.sv
// rv32_decode_pipe: RV32I decode stage with a DEPTH-entry instruction queue.
// Raw {instr, pc} entries wait in a circular FIFO; the head is decoded and
// loaded into a registered output stage that holds while execute cannot take it.
// An empty queue with an empty output stage lets a push go straight to the
// output stage for a one-cycle latency.
// Optional feature macro: DECODE_PERF_CNT_EN adds perf_decoded / perf_stall counters.
module rv32_decode_pipe #(
    parameter int ADDR_WIDTH = 32,
    parameter int XLEN       = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [ADDR_WIDTH-1:0] in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic                  src_stall,
    output logic [6:0]            instr_type,
    output logic [2:0]            funct3,
    output logic [6:0]            funct7,
    output logic [4:0]            rs1,
    output logic [4:0]            rs2,
    output logic [4:0]            rd,
    output logic                  rs1_valid,
    output logic                  rs2_valid,
    output logic                  rd_valid,
    output logic [XLEN-1:0]       imm,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [31:0]           out_instr,
    output logic                  illegal
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [31:0]           perf_decoded,
    output logic [31:0]           perf_stall
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    typedef struct packed {
        logic [6:0]      instr_type;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            rs1_valid;
        logic            rs2_valid;
        logic            rd_valid;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } dec_t;

    // Pure decode of one instruction word. SYSTEM is treated like an I-format
    // (CSR forms read rs1 and write rd). Unknown encodings keep the raw fields
    // but report no register use and a zero immediate.
    function automatic dec_t decode_f(input logic [31:0] instr);
        dec_t       d;
        logic [31:0] imm32;
        logic       rd_wr;
        logic       rd1;
        logic       rd2;
        logic       known;
        d            = '0;
        imm32        = 32'h0000_0000;
        rd_wr        = 1'b0;
        rd1          = 1'b0;
        rd2          = 1'b0;
        known        = 1'b1;
        d.instr_type = instr[6:0];
        d.funct3     = instr[14:12];
        d.funct7     = instr[31:25];
        d.rs1        = instr[19:15];
        d.rs2        = instr[24:20];
        d.rd         = instr[11:7];
        case (instr[6:0])
            OP_R: begin
                rd1 = 1'b1; rd2 = 1'b1; rd_wr = 1'b1;
            end
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
                rd1 = 1'b1; rd_wr = 1'b1;
                imm32 = {{20{instr[31]}}, instr[31:20]};
            end
            OP_STORE: begin
                rd1 = 1'b1; rd2 = 1'b1;
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OP_BRANCH: begin
                rd1 = 1'b1; rd2 = 1'b1;
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                rd_wr = 1'b1;
                imm32 = {instr[31:12], 12'h000};
            end
            OP_JAL: begin
                rd_wr = 1'b1;
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            default: begin
                known = 1'b0;
            end
        endcase
        if (!known || (instr[1:0] != 2'b11)) begin
            d.illegal   = 1'b1;
            d.rs1_valid = 1'b0;
            d.rs2_valid = 1'b0;
            d.rd_valid  = 1'b0;
            imm32       = 32'h0000_0000;
        end else begin
            d.illegal   = 1'b0;
            d.rs1_valid = rd1;
            d.rs2_valid = rd2;
            d.rd_valid  = rd_wr && (instr[11:7] != 5'd0);
        end
        d.imm        = {XLEN{imm32[31]}};
        d.imm[31:0]  = imm32;
        return d;
    endfunction

    logic [31:0]           fifo_instr_r [DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_pc_r    [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic [CNT_W-1:0]      count_next_s;

    logic                  out_valid_r;
    dec_t                  dec_r;
    logic [ADDR_WIDTH-1:0] out_pc_r;
    logic [31:0]           out_instr_r;

    logic                  in_ready_s;
    logic                  fifo_empty_s;
    logic                  push_s;
    logic                  consume_s;
    logic                  load_s;
    logic                  pop_s;
    logic                  fifo_wr_s;
    logic [31:0]           head_instr_s;
    logic [ADDR_WIDTH-1:0] head_pc_s;
    dec_t                  dec_s;

    // Handshake qualification and queue/bypass steering.
    always_comb begin
        in_ready_s   = (count_r < DEPTH_C);
        fifo_empty_s = (count_r == {CNT_W{1'b0}});
        push_s       = in_valid && in_ready_s && !flush;
        consume_s    = out_valid_r && out_ready && !src_stall;
        load_s       = !flush && (!out_valid_r || consume_s) && (!fifo_empty_s || push_s);
        pop_s        = load_s && !fifo_empty_s;
        fifo_wr_s    = push_s && !(load_s && fifo_empty_s);
        if (fifo_empty_s) begin
            head_instr_s = in_instr;
            head_pc_s    = in_pc;
        end else begin
            head_instr_s = fifo_instr_r[rd_ptr_r];
            head_pc_s    = fifo_pc_r[rd_ptr_r];
        end
    end

    assign dec_s = decode_f(head_instr_s);

    // Occupancy after this cycle's write and pop.
    always_comb begin
        case ({fifo_wr_s, pop_s})
            2'b10:   count_next_s = count_r + 1'b1;
            2'b01:   count_next_s = count_r - 1'b1;
            default: count_next_s = count_r;
        endcase
    end

    // Queue storage; only written when an entry is not bypassed.
    always_ff @(posedge clk) begin
        if (fifo_wr_s) begin
            fifo_instr_r[wr_ptr_r] <= in_instr;
            fifo_pc_r[wr_ptr_r]    <= in_pc;
        end
    end

    // Queue pointers and count; flush empties the queue.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (fifo_wr_s) wr_ptr_r <= wr_ptr_r + 1'b1;
            if (pop_s)     rd_ptr_r <= rd_ptr_r + 1'b1;
            count_r <= count_next_s;
        end
    end

    // Output stage: load decoded head, hold while execute is not taking it.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            dec_r       <= '0;
            out_pc_r    <= {ADDR_WIDTH{1'b0}};
            out_instr_r <= 32'h0000_0000;
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            dec_r       <= dec_s;
            out_pc_r    <= head_pc_s;
            out_instr_r <= head_instr_s;
        end else if (consume_s) begin
            out_valid_r <= 1'b0;
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_r;
    assign instr_type = dec_r.instr_type;
    assign funct3     = dec_r.funct3;
    assign funct7     = dec_r.funct7;
    assign rs1        = dec_r.rs1;
    assign rs2        = dec_r.rs2;
    assign rd         = dec_r.rd;
    assign rs1_valid  = dec_r.rs1_valid;
    assign rs2_valid  = dec_r.rs2_valid;
    assign rd_valid   = dec_r.rd_valid;
    assign imm        = dec_r.imm;
    assign illegal    = dec_r.illegal;
    assign out_pc     = out_pc_r;
    assign out_instr  = out_instr_r;

`ifdef DECODE_PERF_CNT_EN
    logic [31:0] perf_decoded_r;
    logic [31:0] perf_stall_r;

    // Free-running wrap-around event counters; flush does not touch them.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_decoded_r <= 32'h0000_0000;
            perf_stall_r   <= 32'h0000_0000;
        end else begin
            if (consume_s)                 perf_decoded_r <= perf_decoded_r + 32'd1;
            if (out_valid_r && src_stall)  perf_stall_r   <= perf_stall_r + 32'd1;
        end
    end

    assign perf_decoded = perf_decoded_r;
    assign perf_stall   = perf_stall_r;
`endif

endmodule
